mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. It consumes the execute stage's registered outputs, performs aligned byte/half/word loads and stores to the data memory through a req/ack handshake, and stalls upstream while an access is outstanding. It registers the write-back payload and drives the MEM→EXE bypass bus from that register.

---
 rtl/mem_stage_pkg.sv | 50 +++++
 rtl/mem_stage_load_store_align.sv | 56 +++++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM states, load/store
// ALU_Control codes (common with decode/EXE) and access-width helpers.
package mem_stage_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    W_BYTE = 2'd0,
    W_HALF = 2'd1,
    W_WORD = 2'd2
  } mem_width_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // Unknown codes on a memory op fall back to a full-word access.
  function automatic mem_width_t op_width(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return W_BYTE;
      OP_LH, OP_LHU, OP_SH: return W_HALF;
      default:              return W_WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic misaligned(input mem_width_t w, input logic [1:0] lo);
    case (w)
      W_HALF:  return lo[0];
      W_WORD:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int cnt_width(input int t);
    return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
  endfunction

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Combinational lane logic: byte enables and replicated store data on the
// way out, lane extraction with sign/zero extension on the way back.
module load_store_align
  import mem_stage_pkg::*;
#(
  parameter bit ENDIAN_BIG = 1'b1
) (
  input  mem_width_t  st_width_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  mem_width_t  ld_width_i,
  input  logic        ld_signed_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_width_i)
      W_BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_be_o    = ENDIAN_BIG ? (4'b1000 >> st_addr_lo_i) : (4'b0001 << st_addr_lo_i);
      end
      W_HALF: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_be_o    = ENDIAN_BIG ? (4'b1100 >> st_addr_lo_i) : (4'b0011 << st_addr_lo_i);
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0; big-endian puts byte 0 at the top.
  always_comb begin
    shamt = 5'd0;
    case (ld_width_i)
      W_BYTE:  shamt = ENDIAN_BIG ? {~ld_addr_lo_i, 3'b000} : {ld_addr_lo_i, 3'b000};
      W_HALF:  shamt = ENDIAN_BIG ? {~ld_addr_lo_i[1], 4'b0000} : {ld_addr_lo_i[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    shifted   = ld_rdata_i >> shamt;
    ld_data_o = shifted;
    case (ld_width_i)
      W_BYTE:  ld_data_o = {{24{ld_signed_i & shifted[7]}}, shifted[7:0]};
      W_HALF:  ld_data_o = {{16{ld_signed_i & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligned loads/stores over a req/ack data
// memory port, upstream stall while outstanding, registered WB payload.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter bit ENDIAN_BIG  = 1'b1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic        RegWrite1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  output logic        Stall_OUT,
  output logic        DMem_Req,
  output logic        DMem_We,
  output logic [31:0] DMem_Addr,
  output logic [31:0] DMem_WData,
  output logic [3:0]  DMem_BE,
  input  logic        DMem_Ack,
  input  logic [31:0] DMem_RData,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic        MemFault1_OUT,
  output logic [4:0]  BypassReg1_MEMEXE,
  output logic [31:0] BypassData1_MEMEXE,
  output logic        BypassValid1_MEMEXE,
  output mem_state_t  Dbg_State_OUT
);

  localparam int CNT_W = cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_t       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q, instr_q, pc_q;
  logic [3:0]       be_q;
  logic             we_q, sign_q, rw_q;
  mem_width_t       width_q;
  logic [4:0]       wreg_q;
  logic [31:0]      instr_out_q, pc_out_q, wb_data_q;
  logic [4:0]       wb_reg_q;
  logic             wb_rw_q, fault_q;

  mem_width_t  in_width;
  logic        in_is_mem, in_misal, in_rw, timeout;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  always_comb begin
    in_width  = op_width(ALU_Control1_IN);
    in_is_mem = MemRead1_IN | MemWrite1_IN;
    in_misal  = misaligned(in_width, ALU_result1_IN[1:0]);
    in_rw     = RegWrite1_IN && (WriteRegister1_IN != 5'd0);
    timeout   = (state_q == ST_ACCESS) && (cnt_q == TO_LAST) && !DMem_Ack;
    cnt_d     = cnt_q + CNT_W'(1);
  end

  load_store_align #(.ENDIAN_BIG(ENDIAN_BIG)) u_align (
    .st_width_i  (in_width),
    .st_addr_lo_i(ALU_result1_IN[1:0]),
    .st_data_i   (MemWriteData1_IN),
    .st_be_o     (st_be),
    .st_wdata_o  (st_wdata),
    .ld_width_i  (width_q),
    .ld_signed_i (sign_q),
    .ld_addr_lo_i(addr_q[1:0]),
    .ld_rdata_i  (DMem_RData),
    .ld_data_o   (ld_data)
  );

  // Data memory handshake: DMem_Req stays high for every ACCESS cycle with
  // address/data/BE/We stable; the access completes in the cycle DMem_Ack is
  // high (RData valid then). Ack outside ACCESS has no effect.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      instr_q     <= '0;
      pc_q        <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      rw_q        <= 1'b0;
      width_q     <= W_BYTE;
      wreg_q      <= '0;
      instr_out_q <= '0;
      pc_out_q    <= '0;
      wb_data_q   <= '0;
      wb_reg_q    <= '0;
      wb_rw_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_is_mem) begin
            wb_rw_q <= 1'b0;
            if (in_misal) begin
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
              cnt_q   <= '0;
              addr_q  <= ALU_result1_IN;
              wdata_q <= st_wdata;
              be_q    <= st_be;
              we_q    <= MemWrite1_IN;
              width_q <= in_width;
              sign_q  <= op_signed(ALU_Control1_IN);
              rw_q    <= in_rw;
              wreg_q  <= WriteRegister1_IN;
              instr_q <= Instr1_IN;
              pc_q    <= Instr1_PC_IN;
            end
          end else begin
            instr_out_q <= Instr1_IN;
            pc_out_q    <= Instr1_PC_IN;
            wb_data_q   <= ALU_result1_IN;
            wb_reg_q    <= WriteRegister1_IN;
            wb_rw_q     <= in_rw;
          end
        end
        ST_ACCESS: begin
          if (DMem_Ack) begin
            state_q     <= ST_IDLE;
            instr_out_q <= instr_q;
            pc_out_q    <= pc_q;
            wb_reg_q    <= wreg_q;
            if (we_q) begin
              wb_rw_q <= 1'b0;
            end else begin
              wb_data_q <= ld_data;
              wb_rw_q   <= rw_q;
            end
          end else if (timeout) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b1;
            wb_rw_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Stall_OUT           = (state_q == ST_ACCESS) && !DMem_Ack && !timeout;
  assign DMem_Req            = (state_q == ST_ACCESS);
  assign DMem_We             = DMem_Req && we_q;
  assign DMem_Addr           = {addr_q[31:2], 2'b00};
  assign DMem_WData          = wdata_q;
  assign DMem_BE             = be_q;
  assign Instr1_OUT          = instr_out_q;
  assign Instr1_PC_OUT       = pc_out_q;
  assign WriteData1_OUT      = wb_data_q;
  assign WriteRegister1_OUT  = wb_reg_q;
  assign RegWrite1_OUT       = wb_rw_q;
  assign MemFault1_OUT       = fault_q;
  assign BypassReg1_MEMEXE   = wb_reg_q;
  assign BypassData1_MEMEXE  = wb_data_q;
  assign BypassValid1_MEMEXE = wb_rw_q;
  assign Dbg_State_OUT       = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random ops, checked against a
// byte-level reference model via expected queues and a negedge monitor.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int ACK_TO = 4;
  localparam bit BIG    = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in, pc_in, alu_in, mwd_in;
  logic [4:0]  wreg_in;
  logic        rw_in, rd_in, wr_in;
  logic [5:0]  ctl_in;
  logic        stall, req, we, ack;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic [31:0] instr_out, pc_out, wb_data;
  logic [4:0]  wb_reg, byp_reg;
  logic        wb_rw, fault, byp_valid;
  logic [31:0] byp_data;
  mem_state_t  dbg_state;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;

  logic [69:0] exp_q[$];      // {fault, reg, data, instr}
  logic [69:0] exp_mem_q[$];  // {addr, be, wdata, we, check_wdata}

  always #5 clk = ~clk;

  mem_stage #(.ENDIAN_BIG(BIG), .ACK_TIMEOUT(ACK_TO)) dut (
    .CLK(clk), .RESET(rst),
    .Instr1_IN(instr_in), .Instr1_PC_IN(pc_in), .ALU_result1_IN(alu_in),
    .WriteRegister1_IN(wreg_in), .MemWriteData1_IN(mwd_in),
    .RegWrite1_IN(rw_in), .MemRead1_IN(rd_in), .MemWrite1_IN(wr_in),
    .ALU_Control1_IN(ctl_in), .Stall_OUT(stall),
    .DMem_Req(req), .DMem_We(we), .DMem_Addr(addr), .DMem_WData(wdata),
    .DMem_BE(be), .DMem_Ack(ack), .DMem_RData(rdata),
    .Instr1_OUT(instr_out), .Instr1_PC_OUT(pc_out), .WriteData1_OUT(wb_data),
    .WriteRegister1_OUT(wb_reg), .RegWrite1_OUT(wb_rw), .MemFault1_OUT(fault),
    .BypassReg1_MEMEXE(byp_reg), .BypassData1_MEMEXE(byp_data),
    .BypassValid1_MEMEXE(byp_valid), .Dbg_State_OUT(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_bytes(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit model_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic int lane_of(input int k);
    return BIG ? 3 - k : k;
  endfunction

  function automatic logic [31:0] model_load(input int a, input int n, input bit sgn,
                                             input logic [31:0] rd);
    logic [7:0]  b[4];
    logic [31:0] v;
    for (int k = 0; k < 4; k++) b[k] = rd[8*lane_of(k) +: 8];
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(b[a+i]) << (8 * (BIG ? (n - 1 - i) : i)));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] model_be(input int a, input int n);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < n; i++) m[lane_of(a + i)] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] d);
    if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_nop();
    instr_in = 32'd0; pc_in = 32'd0; alu_in = 32'd0; mwd_in = 32'd0;
    wreg_in = 5'd0; rw_in = 1'b0; rd_in = 1'b0; wr_in = 1'b0; ctl_in = 6'd0;
  endtask

  task automatic issue(input logic [5:0] op, input logic rd, input logic wr,
                       input logic [31:0] a32, input logic [31:0] sd,
                       input logic [4:0] wr_reg, input logic rw, input int d,
                       input logic [31:0] rdv);
    int n, a, reqc, stc;
    bit is_mem, mis, tmo;
    logic [31:0] ins;
    n      = model_bytes(op);
    a      = int'(a32[1:0]);
    is_mem = rd || wr;
    mis    = is_mem && (a % n != 0);
    tmo    = (d >= ACK_TO);
    ins    = $urandom;
    @(negedge clk);
    instr_in = ins; pc_in = $urandom; alu_in = a32; mwd_in = sd;
    wreg_in = wr_reg; rw_in = rw; rd_in = rd; wr_in = wr; ctl_in = op;
    if (!is_mem) begin
      ack   = 1'($urandom_range(0, 1));
      rdata = $urandom;
    end
    if (!is_mem) begin
      if (rw && wr_reg != 5'd0) exp_q.push_back({1'b0, wr_reg, a32, ins});
    end else if (mis) begin
      exp_q.push_back({1'b1, 69'd0});
    end else begin
      exp_mem_q.push_back({a32 & ~32'h3, model_be(a, n), model_wdata(n, sd), wr, wr});
      if (tmo) exp_q.push_back({1'b1, 69'd0});
      else if (!wr && rw && wr_reg != 5'd0)
        exp_q.push_back({1'b0, wr_reg, model_load(a, n, model_signed(op), rdv), ins});
    end
    @(posedge clk);
    #1;
    drive_nop();
    ack = 1'b0;
    if (is_mem && !mis) begin
      reqc = 0;
      stc  = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!req) break;
        reqc++;
        rdata = (reqc == d + 1) ? rdv : $urandom;
        ack   = (reqc == d + 1);
        #1;
        if (stall) stc++;
        @(posedge clk);
        #1;
        ack = 1'b0;
      end
      chk("req_cycles", 32'(reqc), 32'(tmo ? ACK_TO : d + 1));
      chk("stall_cycles", 32'(stc), 32'(tmo ? ACK_TO - 1 : d));
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        req_prev;
    bit          have_m;
    logic [69:0] m, w;
    req_prev = 1'b0;
    have_m   = 1'b0;
    m        = '0;
    while (!done) begin
      @(negedge clk);
      #2;
      if (rst) begin
        req_prev = 1'b0;
        continue;
      end
      if (req) begin
        if (!req_prev) begin
          if (exp_mem_q.size() == 0) begin
            flag("unexpected_req");
            have_m = 1'b0;
          end else begin
            m      = exp_mem_q.pop_front();
            have_m = 1'b1;
          end
        end
        if (have_m) begin
          chk("dmem_addr", addr, m[69:38]);
          chk("dmem_be", 32'(be), 32'(m[37:34]));
          chk("dmem_we", 32'(we), 32'(m[1]));
          if (m[0]) chk("dmem_wdata", wdata, m[33:2]);
        end
      end
      req_prev = req;
      if (wb_rw || fault) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_wb");
        end else begin
          w = exp_q.pop_front();
          chk("wb_fault", 32'(fault), 32'(w[69]));
          chk("wb_regwrite", 32'(wb_rw), 32'(!w[69]));
          chk("bypass_valid", 32'(byp_valid), 32'(!w[69]));
          if (!w[69]) begin
            chk("wb_reg", 32'(wb_reg), 32'(w[68:64]));
            chk("wb_data", wb_data, w[63:32]);
            chk("wb_instr", instr_out, w[31:0]);
            chk("bypass_reg", 32'(byp_reg), 32'(w[68:64]));
            chk("bypass_data", byp_data, w[63:32]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]  ops[9];
    logic [31:0] ra;
    int          k, n;
    logic        rd, wr;
    ops = '{6'h00, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    rst = 1'b1;
    drive_nop();
    ack = 1'b0;
    rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_regwrite", 32'(wb_rw), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    issue(6'h00, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd5, 1'b1, 0, 32'd0);
    issue(OP_LB, 1'b1, 1'b0, 32'h103, 32'd0, 5'd7, 1'b1, 3, 32'h0000_00F0);
    issue(OP_LBU, 1'b1, 1'b0, 32'h103, 32'd0, 5'd8, 1'b1, 3, 32'h0000_00F0);
    issue(OP_SH, 1'b0, 1'b1, 32'h202, 32'hABCD, 5'd9, 1'b1, 1, 32'd0);
    issue(OP_LW, 1'b1, 1'b0, 32'h101, 32'd0, 5'd4, 1'b1, 0, 32'd0);
    issue(OP_LW, 1'b1, 1'b0, 32'h400, 32'd0, 5'd6, 1'b1, 9, 32'd0);
    issue(OP_LH, 1'b1, 1'b0, 32'h502, 32'd0, 5'd10, 1'b1, ACK_TO - 1, 32'h1234_8765);
    issue(6'h00, 1'b0, 1'b0, 32'h55, 32'd0, 5'd0, 1'b1, 0, 32'd0);
    chk("reg0_regwrite", 32'(wb_rw), 32'd0);
    issue(OP_SW, 1'b1, 1'b1, 32'h600, 32'hDEAD_BEEF, 5'd3, 1'b1, 0, 32'd0);

    // Reset in the middle of an outstanding load, then a stale ack.
    @(negedge clk);
    alu_in = 32'h300; rd_in = 1'b1; ctl_in = OP_LW; wreg_in = 5'd11; rw_in = 1'b1;
    exp_mem_q.push_back({32'h300, 4'b1111, 32'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    drive_nop();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_ACCESS));
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_addr", addr, 32'd0);
    chk("midrst_be", 32'(be), 32'd0);
    chk("midrst_fault", 32'(fault), 32'd0);
    chk("midrst_bypass", 32'(byp_valid), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    rdata = 32'hCAFE_F00D;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("late_ack_req", 32'(req), 32'd0);
      chk("late_ack_regwrite", 32'(wb_rw), 32'd0);
    end
    ack = 1'b0;

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 8);
      n  = model_bytes(ops[k]);
      rd = (k >= 1 && k <= 5) ? 1'b1 : (k >= 6 ? 1'($urandom_range(0, 1)) : 1'b0);
      wr = (k >= 6);
      ra = $urandom;
      if ($urandom_range(0, 2) != 0) ra = ra & ~32'(n - 1);
      issue(ops[k], rd, wr, ra, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), $urandom_range(0, 5), $urandom);
    end

    repeat (3) @(negedge clk);
    done = 1'b1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_mem_q_empty", 32'(exp_mem_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
